// File: rtl/audio_mix_sequencer.sv
// Audio mixer sequencer: snapshots seven source terms on a mix request,
// accumulates them serially into left/right accumulators, applies master
// volume as an arithmetic shift, clamps to 16 bits and presents the result.
module audio_mix_sequencer #(
    parameter int ACC_W = 20
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        sample_stb,
    input  logic [15:0] opll_i,
    input  logic [15:0] opl3_l_i,
    input  logic [15:0] opl3_r_i,
    input  logic [14:0] scc1_l_i,
    input  logic [14:0] scc1_r_i,
    input  logic [14:0] scc2_l_i,
    input  logic [14:0] scc2_r_i,
    input  logic [8:0]  psg_i,
    input  logic [7:0]  pcm_i,
    input  logic        tape_en,
    input  logic        ear_i,
    input  logic [2:0]  vol_i,
    output logic [15:0] out_l,
    output logic [15:0] out_r,
    output logic        out_valid,
    output logic        busy,
    output logic [7:0]  overrun_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_SUM, S_SCALE, S_OUT} state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-15){1'b0}}, {15{1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-15){1'b1}}, 15'b0};

    state_t                   r_state;
    logic        [2:0]        r_idx;
    logic signed [ACC_W-1:0]  r_acc_l;
    logic signed [ACC_W-1:0]  r_acc_r;

    // Snapshot of every mix input, frozen for the duration of a mix
    logic [15:0] r_opll, r_opl3_l, r_opl3_r;
    logic [14:0] r_scc1_l, r_scc1_r, r_scc2_l, r_scc2_r;
    logic [8:0]  r_psg;
    logic [7:0]  r_pcm;
    logic        r_tape_en, r_ear;
    logic [2:0]  r_vol;

    logic [15:0]              w_term_l, w_term_r;
    logic signed [ACC_W-1:0]  w_ext_l, w_ext_r;
    logic signed [ACC_W-1:0]  w_sum_l, w_sum_r;
    logic signed [ACC_W-1:0]  w_scl_l, w_scl_r;
    logic [2:0]               w_shamt;
    logic                     w_start;

    assign w_start = (r_state == S_IDLE) && sample_stb;

    function automatic logic [15:0] clamp16(input logic signed [ACC_W-1:0] x);
        if (x > ACC_MAX)      return 16'h7fff;
        else if (x < ACC_MIN) return 16'h8000;
        else                  return x[15:0];
    endfunction

    // Select the 16-bit term for the current index (all terms are 16-bit signed)
    always_comb begin
        w_term_l = '0;
        w_term_r = '0;
        case (r_idx)
            3'd0: begin w_term_l = r_opll;                 w_term_r = r_opll;                 end
            3'd1: begin w_term_l = r_opl3_l;               w_term_r = r_opl3_r;               end
            3'd2: begin w_term_l = {r_scc1_l[14], r_scc1_l}; w_term_r = {r_scc1_r[14], r_scc1_r}; end
            3'd3: begin w_term_l = {r_scc2_l[14], r_scc2_l}; w_term_r = {r_scc2_r[14], r_scc2_r}; end
            3'd4: begin w_term_l = {1'b0, r_psg, 6'b0};    w_term_r = {1'b0, r_psg, 6'b0};    end
            3'd5: begin w_term_l = {r_pcm, r_pcm};         w_term_r = {r_pcm, r_pcm};         end
            3'd6: begin
                if (r_tape_en) begin
                    w_term_l = {8'b0, r_ear, 7'b0};
                    w_term_r = {8'b0, r_ear, 7'b0};
                end
            end
            default: ;
        endcase
    end

    assign w_ext_l = {{(ACC_W-16){w_term_l[15]}}, w_term_l};
    assign w_ext_r = {{(ACC_W-16){w_term_r[15]}}, w_term_r};
    assign w_sum_l = r_acc_l + w_ext_l;
    assign w_sum_r = r_acc_r + w_ext_r;

    // Volume: shift by (7 - vol); vol 0 is a hard mute rather than a >>>7
    assign w_shamt = 3'd7 - r_vol;
    assign w_scl_l = (r_vol == 3'd0) ? '0 : (r_acc_l >>> w_shamt);
    assign w_scl_r = (r_vol == 3'd0) ? '0 : (r_acc_r >>> w_shamt);

    // Capture the inputs on an accepted request so later changes cannot leak in
    always_ff @(posedge clk_sys) begin
        if (!reset && w_start) begin
            r_opll    <= opll_i;
            r_opl3_l  <= opl3_l_i;
            r_opl3_r  <= opl3_r_i;
            r_scc1_l  <= scc1_l_i;
            r_scc1_r  <= scc1_r_i;
            r_scc2_l  <= scc2_l_i;
            r_scc2_r  <= scc2_r_i;
            r_psg     <= psg_i;
            r_pcm     <= pcm_i;
            r_tape_en <= tape_en;
            r_ear     <= ear_i;
            r_vol     <= vol_i;
        end
    end

    // Sequencer FSM with registered outputs and overrun counter.
    // The clamped result is loaded on the SCALE->OUT edge so that out_valid
    // and the new sample are visible during the OUT cycle itself.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_acc_l     <= '0;
            r_acc_r     <= '0;
            out_l       <= '0;
            out_r       <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            out_valid <= 1'b0;
            if (sample_stb && (r_state != S_IDLE) && (overrun_cnt != 8'hff))
                overrun_cnt <= overrun_cnt + 8'd1;
            case (r_state)
                S_IDLE: begin
                    if (sample_stb) begin
                        r_acc_l <= '0;
                        r_acc_r <= '0;
                        r_idx   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_SUM;
                    end
                end
                S_SUM: begin
                    r_acc_l <= w_sum_l;
                    r_acc_r <= w_sum_r;
                    if (r_idx == 3'd6) r_state <= S_SCALE;
                    else               r_idx   <= r_idx + 3'd1;
                end
                S_SCALE: begin
                    r_acc_l   <= w_scl_l;
                    r_acc_r   <= w_scl_r;
                    out_l     <= clamp16(w_scl_l);
                    out_r     <= clamp16(w_scl_r);
                    out_valid <= 1'b1;
                    r_state   <= S_OUT;
                end
                S_OUT: begin
                    busy    <= 1'b0;
                    r_idx   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_mix_sequencer.sv
// Scoreboard bench for audio_mix_sequencer: stimulus pushes expected L/R
// pairs, a negedge monitor pops and compares on every out_valid.
module tb_audio_mix_sequencer;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        sample_stb;
    logic [15:0] opll_i, opl3_l_i, opl3_r_i;
    logic [14:0] scc1_l_i, scc1_r_i, scc2_l_i, scc2_r_i;
    logic [8:0]  psg_i;
    logic [7:0]  pcm_i;
    logic        tape_en, ear_i;
    logic [2:0]  vol_i;
    logic [15:0] out_l, out_r;
    logic        out_valid, busy;
    logic [7:0]  overrun_cnt;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int exp_l[$];
    int exp_r[$];

    audio_mix_sequencer #(.ACC_W(20)) dut (
        .clk_sys(clk_sys), .reset(reset), .sample_stb(sample_stb),
        .opll_i(opll_i), .opl3_l_i(opl3_l_i), .opl3_r_i(opl3_r_i),
        .scc1_l_i(scc1_l_i), .scc1_r_i(scc1_r_i),
        .scc2_l_i(scc2_l_i), .scc2_r_i(scc2_r_i),
        .psg_i(psg_i), .pcm_i(pcm_i), .tape_en(tape_en), .ear_i(ear_i),
        .vol_i(vol_i), .out_l(out_l), .out_r(out_r), .out_valid(out_valid),
        .busy(busy), .overrun_cnt(overrun_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string nm, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every out_valid must match the oldest expected pair
    always @(negedge clk_sys) begin
        if (out_valid) begin
            if (exp_l.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL unexpected_out_valid: got l=%0d r=%0d expected none",
                         $signed(out_l), $signed(out_r));
            end else begin
                chk("out_l", int'($signed(out_l)), exp_l.pop_front());
                chk("out_r", int'($signed(out_r)), exp_r.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic zero_inputs();
        opll_i = '0; opl3_l_i = '0; opl3_r_i = '0;
        scc1_l_i = '0; scc1_r_i = '0; scc2_l_i = '0; scc2_r_i = '0;
        psg_i = '0; pcm_i = '0; tape_en = 1'b0; ear_i = 1'b0; vol_i = 3'd7;
    endtask

    // Drive one request sampled on the next edge; returns in cycle 1
    task automatic start();
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
    endtask

    // Wait (bounded) for out_valid, then step back into IDLE
    task automatic wait_valid();
        int n = 0;
        @(negedge clk_sys);
        while (!out_valid && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        if (!out_valid) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL timeout: got no out_valid expected one within 20 cycles");
        end
        tick();
    endtask

    task automatic run_mix(input int el, input int er);
        exp_l.push_back(el);
        exp_r.push_back(er);
        start();
        wait_valid();
    endtask

    // Cycle-accurate check after a start(): valid only in cycle 9, busy 1..9
    task automatic check_timing();
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk_sys);
            chk($sformatf("out_valid_c%0d", k), int'(out_valid), (k == 9) ? 1 : 0);
            chk($sformatf("busy_c%0d", k), int'(busy), (k <= 9) ? 1 : 0);
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        sample_stb = 1'b0;
        zero_inputs();
        tick(); tick();
        @(negedge clk_sys);
        chk("rst_out_l", int'(out_l), 0);
        chk("rst_out_r", int'(out_r), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun_cnt), 0);
        tick();
        reset = 1'b0;
        tick();

        // Basic latency / busy profile
        opll_i = 16'd1000;
        exp_l.push_back(1000); exp_r.push_back(1000);
        start();
        check_timing();

        // Clamping on both rails
        zero_inputs();
        opll_i = 16'h7fff; opl3_l_i = 16'h7fff; opl3_r_i = 16'h8000;
        scc1_r_i = 15'h4000; scc2_r_i = 15'h4000;
        run_mix(32767, -32768);

        // Volume, PSG, PCM and tape terms
        zero_inputs(); opll_i = 16'd8000; vol_i = 3'd5; run_mix(2000, 2000);
        zero_inputs(); opll_i = 16'd8000; vol_i = 3'd0; run_mix(0, 0);
        zero_inputs(); psg_i = 9'd511;                  run_mix(32704, 32704);
        zero_inputs(); pcm_i = 8'd1;                    run_mix(257, 257);
        zero_inputs(); pcm_i = 8'hff;                   run_mix(-1, -1);
        zero_inputs(); tape_en = 1'b1; ear_i = 1'b1;    run_mix(128, 128);
        zero_inputs(); tape_en = 1'b0; ear_i = 1'b1;    run_mix(0, 0);
        // Mixed L/R with SCC on the left only, half volume
        zero_inputs(); opll_i = 16'd100; scc1_l_i = 15'd300; scc2_l_i = 15'h7f9c;
        vol_i = 3'd6; run_mix(150, 50);

        // Overruns: stb at cycles 0, 3 and 9
        reset = 1'b1; tick(); reset = 1'b0; tick();
        zero_inputs(); opll_i = 16'd1000;
        exp_l.push_back(1000); exp_r.push_back(1000);
        start();                        // now cycle 1
        tick(); tick();                 // cycle 3
        sample_stb = 1'b1; tick(); sample_stb = 1'b0;   // cycle 4
        repeat (5) tick();              // cycle 9
        sample_stb = 1'b1; tick(); sample_stb = 1'b0;   // cycle 10
        @(negedge clk_sys);
        chk("overrun_two", int'(overrun_cnt), 2);
        chk("idle_after_overrun", int'(busy), 0);
        tick(); tick();

        // Saturation: 34 mixes x 9 overrun pulses each
        for (int m = 0; m < 34; m++) begin
            exp_l.push_back(1000); exp_r.push_back(1000);
            sample_stb = 1'b1;
            repeat (10) tick();
            sample_stb = 1'b0;
            tick();
        end
        @(negedge clk_sys);
        chk("overrun_sat", int'(overrun_cnt), 255);
        chk("scoreboard_drain_sat", exp_l.size(), 0);
        tick();

        // Reset mid-mix aborts without a pulse
        zero_inputs(); opll_i = 16'd4000;
        start();                        // cycle 1
        tick(); tick(); tick();         // cycle 4
        reset = 1'b1; sample_stb = 1'b1;
        tick();                         // cycle 5
        reset = 1'b0; sample_stb = 1'b0;
        @(negedge clk_sys);
        chk("abort_out_l", int'(out_l), 0);
        chk("abort_out_r", int'(out_r), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_overrun", int'(overrun_cnt), 0);
        tick();                         // cycle 6
        exp_l.push_back(4000); exp_r.push_back(4000);
        start();
        check_timing();                 // valid at cycle 15

        // Snapshot isolation: change inputs at cycle 2
        zero_inputs(); opll_i = 16'd1000; opl3_l_i = 16'd10;
        exp_l.push_back(1010); exp_r.push_back(1000);
        start(); tick();                // cycle 2
        opll_i = 16'd5000; opl3_l_i = 16'd7000; opl3_r_i = 16'd300;
        psg_i = 9'd100; vol_i = 3'd1; tape_en = 1'b1; ear_i = 1'b1;
        wait_valid();
        tick(); tick();

        chk("scoreboard_drain", exp_l.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
